luma_threshold_ctrl: RTL and testbench

Frame-level controller for the binary threshold filter in the camera-to-VGA pixel path. It sits beside the filter on the pixel stream and computes each frame's mean luminance. At frame end it divides the accumulated sum by the pixel count with a sequential divider, then publishes the threshold the filter uses for the next frame. A manual mode replaces the adaptive value with a user-loaded threshold.

---
 rtl/luma_threshold_ctrl_if.sv | 28 ++
 rtl/luma_threshold_ctrl.sv | 125 ++++++++++++
 tb/tb_luma_threshold_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/luma_threshold_ctrl_if.sv
// Pixel-stream, control and threshold/mean result signals shared between
// the frame threshold controller and its environment.
interface luma_threshold_ctrl_if;
   logic       i_vsync;
   logic       i_pix_valid;
   logic [3:0] i_r;
   logic [3:0] i_g;
   logic [3:0] i_b;
   logic       i_mode_adaptive;
   logic [3:0] i_thr_manual;
   logic       i_thr_load;
   logic [3:0] o_threshold;
   logic       o_thr_valid;
   logic [3:0] o_frame_mean;
   logic       o_mean_valid;
   logic       o_frame_skip;
   logic       o_busy;

   modport master (
      output i_vsync, i_pix_valid, i_r, i_g, i_b, i_mode_adaptive, i_thr_manual, i_thr_load,
      input  o_threshold, o_thr_valid, o_frame_mean, o_mean_valid, o_frame_skip, o_busy
   );

   modport slave (
      input  i_vsync, i_pix_valid, i_r, i_g, i_b, i_mode_adaptive, i_thr_manual, i_thr_load,
      output o_threshold, o_thr_valid, o_frame_mean, o_mean_valid, o_frame_skip, o_busy
   );
endinterface

// File: rtl/luma_threshold_ctrl.sv
// Frame mean-luminance accumulator with a sequential restoring divider that
// publishes the binary filter threshold for the next frame.
module luma_threshold_ctrl #(
   parameter int unsigned CNT_W      = 20,
   parameter logic [3:0]  FIXED_THR  = 4'd8,
   parameter int unsigned MIN_PIXELS = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   luma_threshold_ctrl_if.slave bus
);
   localparam int unsigned SUM_W = CNT_W + 4;
   localparam int unsigned IT_W  = $clog2(SUM_W);

   typedef enum logic [1:0] {IDLE, DIVIDE, UPDATE} state_t;

   state_t           state;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt;
   logic             vs_d;
   logic [SUM_W-1:0] quo;
   logic [CNT_W-1:0] rem;
   logic [CNT_W-1:0] divisor;
   logic [IT_W-1:0]  it_cnt;

   logic [5:0]       pix_sum_c;
   logic [3:0]       luma_c;
   logic             rise_c;
   logic             accept_c;
   logic [CNT_W:0]   rem_shift_c;
   logic             rem_geq_c;
   logic [CNT_W-1:0] rem_next_c;
   logic [3:0]       quo_sat_c;

   assign pix_sum_c = 6'(bus.i_r) + 6'(bus.i_g) + 6'(bus.i_b);
   assign luma_c    = 4'(pix_sum_c / 6'd3);
   assign rise_c    = bus.i_vsync & ~vs_d;
   assign accept_c  = (cnt >= CNT_W'(MIN_PIXELS));

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   assign rem_shift_c = {rem, quo[SUM_W-1]};
   assign rem_geq_c   = (rem_shift_c >= {1'b0, divisor});
   assign rem_next_c  = rem_geq_c ? CNT_W'(rem_shift_c - {1'b0, divisor})
                                  : rem_shift_c[CNT_W-1:0];
   assign quo_sat_c   = (|quo[SUM_W-1:4]) ? 4'hF : quo[3:0];

   // Frame accumulators; a frame-end rise restarts them with the current pixel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum  <= '0;
         cnt  <= '0;
         vs_d <= 1'b0;
      end else begin
         vs_d <= bus.i_vsync;
         if (rise_c) begin
            sum <= bus.i_pix_valid ? SUM_W'(luma_c) : '0;
            cnt <= bus.i_pix_valid ? CNT_W'(1) : '0;
         end else if (bus.i_pix_valid && !(&cnt)) begin
            sum <= sum + SUM_W'(luma_c);
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Control FSM, divider datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         quo              <= '0;
         rem              <= '0;
         divisor          <= '0;
         it_cnt           <= '0;
         bus.o_threshold  <= FIXED_THR;
         bus.o_thr_valid  <= 1'b0;
         bus.o_frame_mean <= 4'd0;
         bus.o_mean_valid <= 1'b0;
         bus.o_frame_skip <= 1'b0;
         bus.o_busy       <= 1'b0;
      end else begin
         bus.o_thr_valid  <= 1'b0;
         bus.o_mean_valid <= 1'b0;
         bus.o_frame_skip <= 1'b0;
         case (state)
            IDLE: begin
               if (rise_c) begin
                  if (accept_c) begin
                     quo        <= sum;
                     divisor    <= cnt;
                     rem        <= '0;
                     it_cnt     <= '0;
                     bus.o_busy <= 1'b1;
                     state      <= DIVIDE;
                  end else begin
                     bus.o_frame_skip <= 1'b1;
                  end
               end
            end
            DIVIDE: begin
               rem    <= rem_next_c;
               quo    <= {quo[SUM_W-2:0], rem_geq_c};
               it_cnt <= it_cnt + IT_W'(1);
               if (it_cnt == IT_W'(SUM_W - 1)) state <= UPDATE;
               if (rise_c) bus.o_frame_skip <= 1'b1;
            end
            UPDATE: begin
               bus.o_frame_mean <= quo_sat_c;
               bus.o_mean_valid <= 1'b1;
               if (bus.i_mode_adaptive) begin
                  bus.o_threshold <= quo_sat_c;
                  bus.o_thr_valid <= 1'b1;
               end
               bus.o_busy <= 1'b0;
               state      <= IDLE;
               if (rise_c) bus.o_frame_skip <= 1'b1;
            end
            default: state <= IDLE;
         endcase
         // Manual and adaptive writes are mutually exclusive by mode.
         if (!bus.i_mode_adaptive && bus.i_thr_load) begin
            bus.o_threshold <= bus.i_thr_manual;
            bus.o_thr_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_luma_threshold_ctrl.sv
// Self-checking bench: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_luma_threshold_ctrl;
   localparam int unsigned CNT_W = 20;
   localparam int unsigned SUM_W = CNT_W + 4;
   localparam int          LAT   = SUM_W + 1;

   logic clk = 1'b0;
   logic rst_n;
   luma_threshold_ctrl_if bus ();

   luma_threshold_ctrl #(.CNT_W(CNT_W), .FIXED_THR(4'd8), .MIN_PIXELS(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frame sums in plain integers; a pending result is
   // released LAT edges after the frame-end rise that accepted it.
   int m_sum, m_cnt, m_cd, m_q, m_luma;
   bit m_vs, m_rise, m_busy_now, model_ok = 1'b0;
   int e_thr, e_mean;
   bit e_tv, e_mv, e_skip, e_busy;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_sum = 0; m_cnt = 0; m_vs = 0; m_cd = 0; m_q = 0;
         e_thr = 8; e_mean = 0; e_tv = 0; e_mv = 0; e_skip = 0; e_busy = 0;
         model_ok = 1'b1;
      end else begin
         m_luma = (int'(bus.i_r) + int'(bus.i_g) + int'(bus.i_b)) / 3;
         m_rise = bus.i_vsync && !m_vs;
         m_vs   = bus.i_vsync;
         e_tv = 0; e_mv = 0; e_skip = 0;
         m_busy_now = (m_cd > 0);
         if (m_busy_now) begin
            m_cd--;
            if (m_cd == 0) begin
               e_mean = m_q; e_mv = 1; e_busy = 0;
               if (bus.i_mode_adaptive) begin e_thr = m_q; e_tv = 1; end
            end
         end
         if (m_rise) begin
            if (!m_busy_now && m_cnt >= 16) begin
               m_q = m_sum / m_cnt;
               if (m_q > 15) m_q = 15;
               m_cd = LAT; e_busy = 1;
            end else begin
               e_skip = 1;
            end
            m_sum = bus.i_pix_valid ? m_luma : 0;
            m_cnt = bus.i_pix_valid ? 1 : 0;
         end else if (bus.i_pix_valid && m_cnt < (1 << CNT_W) - 1) begin
            m_sum += m_luma;
            m_cnt++;
         end
         if (!bus.i_mode_adaptive && bus.i_thr_load) begin
            e_thr = int'(bus.i_thr_manual); e_tv = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("threshold",  32'(bus.o_threshold),  32'(e_thr));
         chk("frame_mean", 32'(bus.o_frame_mean), 32'(e_mean));
         chk("thr_valid",  32'(bus.o_thr_valid),  32'(e_tv));
         chk("mean_valid", 32'(bus.o_mean_valid), 32'(e_mv));
         chk("frame_skip", 32'(bus.o_frame_skip), 32'(e_skip));
         chk("busy",       32'(bus.o_busy),       32'(e_busy));
      end
   end

   task automatic send_pixels(input int n, input int r, input int g, input int b);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.i_pix_valid = 1'b1;
         bus.i_r = 4'(r); bus.i_g = 4'(g); bus.i_b = 4'(b);
      end
      @(negedge clk);
      bus.i_pix_valid = 1'b0;
   endtask

   // Raise vsync (optionally again at edge E+second_k) and watch a bounded window.
   task automatic close_frame(input int second_k, output int mean_k, output int mean_v,
                              output int thr_v, output int tv_v, output int skip_k,
                              output int n_skip);
      mean_k = -1; mean_v = -1; thr_v = -1; tv_v = -1; skip_k = -1; n_skip = 0;
      bus.i_vsync = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.o_mean_valid === 1'b1 && mean_k < 0) begin
            mean_k = k; mean_v = int'(bus.o_frame_mean);
            thr_v = int'(bus.o_threshold); tv_v = int'(bus.o_thr_valid);
         end
         if (bus.o_frame_skip === 1'b1) begin
            n_skip++;
            if (skip_k < 0) skip_k = k;
         end
         bus.i_vsync = (k == 0) || (second_k > 0 && (k + 1 == second_k || k == second_k));
      end
      bus.i_vsync = 1'b0;
   endtask

   int mk, mv, tv, tvv, sk, ns, nvalid;

   initial begin
      bus.i_vsync = 0; bus.i_pix_valid = 0; bus.i_r = 0; bus.i_g = 0; bus.i_b = 0;
      bus.i_mode_adaptive = 1; bus.i_thr_manual = 0; bus.i_thr_load = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_thr",  32'(bus.o_threshold), 32'd8);
      chk("reset_mean", 32'(bus.o_frame_mean), 32'd0);
      chk("reset_flags", 32'({bus.o_thr_valid, bus.o_mean_valid, bus.o_frame_skip, bus.o_busy}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send_pixels(64, 6, 6, 6);
      close_frame(0, mk, mv, tv, tvv, sk, ns);
      chk("uniform_latency", 32'(mk), 32'(LAT));
      chk("uniform_mean", 32'(mv), 32'd6);
      chk("uniform_thr", 32'(tv), 32'd6);
      chk("uniform_thr_valid", 32'(tvv), 32'd1);
      chk("uniform_no_skip", 32'(ns), 32'd0);

      send_pixels(32, 15, 15, 15);
      send_pixels(32, 0, 0, 0);
      close_frame(0, mk, mv, tv, tvv, sk, ns);
      chk("mixed_latency", 32'(mk), 32'(LAT));
      chk("mixed_mean", 32'(mv), 32'd7);
      chk("mixed_thr", 32'(tv), 32'd7);

      send_pixels(10, 6, 6, 6);
      close_frame(0, mk, mv, tv, tvv, sk, ns);
      chk("short_skip_at", 32'(sk), 32'd0);
      chk("short_skip_count", 32'(ns), 32'd1);
      chk("short_no_mean", 32'(mk), 32'hFFFF_FFFF);
      chk("short_thr_kept", 32'(bus.o_threshold), 32'd7);

      bus.i_mode_adaptive = 0; bus.i_thr_manual = 4'd12; bus.i_thr_load = 1;
      @(negedge clk);
      bus.i_thr_load = 0;
      chk("manual_thr", 32'(bus.o_threshold), 32'd12);
      chk("manual_thr_valid", 32'(bus.o_thr_valid), 32'd1);
      send_pixels(20, 9, 0, 0);
      close_frame(0, mk, mv, tv, tvv, sk, ns);
      chk("manual_mean", 32'(mv), 32'd3);
      chk("manual_thr_kept", 32'(tv), 32'd12);
      chk("manual_no_thr_valid", 32'(tvv), 32'd0);

      bus.i_mode_adaptive = 1; bus.i_thr_manual = 4'd2; bus.i_thr_load = 1;
      @(negedge clk);
      bus.i_thr_load = 0;
      chk("adaptive_load_ignored", 32'(bus.o_threshold), 32'd12);

      send_pixels(20, 15, 0, 0);
      close_frame(5, mk, mv, tv, tvv, sk, ns);
      chk("overlap_latency", 32'(mk), 32'(LAT));
      chk("overlap_mean", 32'(mv), 32'd5);
      chk("overlap_thr", 32'(tv), 32'd5);
      chk("overlap_skip_at", 32'(sk), 32'd5);
      chk("overlap_skip_count", 32'(ns), 32'd1);

      send_pixels(20, 6, 6, 6);
      bus.i_vsync = 1'b1;
      @(negedge clk);
      bus.i_vsync = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nvalid = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.o_mean_valid !== 1'b0 || bus.o_thr_valid !== 1'b0) nvalid++;
      end
      chk("abort_no_valid", 32'(nvalid), 32'd0);
      chk("abort_thr", 32'(bus.o_threshold), 32'd8);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 2499) != 0);
         bus.i_pix_valid = ($urandom_range(0, 9) < 7);
         bus.i_r = 4'($urandom_range(0, 15));
         bus.i_g = 4'($urandom_range(0, 15));
         bus.i_b = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) < 2) bus.i_vsync = ~bus.i_vsync;
         bus.i_thr_load   = ($urandom_range(0, 49) == 0);
         bus.i_thr_manual = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) bus.i_mode_adaptive = ~bus.i_mode_adaptive;
      end
      @(negedge clk);
      rst_n = 1'b1; bus.i_pix_valid = 0; bus.i_thr_load = 0; bus.i_vsync = 0;
      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
